// File: rtl/dmem_responder_if.sv
// Core-side data memory bus between the EX/MEM stage and the responder.
// The core drives requests; the responder answers with a one-cycle strobe.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  rdata_o, ready_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output rdata_o, ready_o, err_o, busy_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-ported data memory with programmable wait states and
// byte-lane writes; answers one access at a time.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input logic clk,
    input logic rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        l_we;
    logic [3:0]  l_be;
    logic [29:0] l_word;
    logic [31:0] l_wdata;

    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] rdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        acc_we;
    logic [3:0]  acc_be;
    logic [29:0] acc_word;
    logic        acc_legal;
    logic        acc_bad;
    logic        enter_resp;
    logic        unused_lsb;

    assign unused_lsb = ^bus.addr_i[1:0];

    // With zero wait states the response is built straight from the bus.
    always_comb begin
        acc_we   = l_we;
        acc_be   = l_be;
        acc_word = l_word;
        if (state == IDLE) begin
            acc_we   = bus.we_i;
            acc_be   = bus.be_i;
            acc_word = bus.addr_i[31:2];
        end
    end

    always_comb begin
        acc_legal = 1'b0;
        case (acc_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: acc_legal = 1'b1;
            default: acc_legal = 1'b0;
        endcase
    end

    assign acc_bad = !acc_legal || (acc_word[29:AW] != '0);

    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE && bus.req_i && WAIT_STATES == 0)
            enter_resp = 1'b1;
        else if (state == WAIT && cnt == 4'd0)
            enter_resp = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        l_we    <= bus.we_i;
                        l_be    <= bus.be_i;
                        l_word  <= bus.addr_i[31:2];
                        l_wdata <= bus.wdata_i;
                        busy    <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // Array read happens only here; the write is one edge later.
            if (enter_resp) begin
                ready <= 1'b1;
                err   <= acc_bad;
                if (!acc_we)
                    rdata <= acc_bad ? '0 : mem[acc_word[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == RESP && l_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (l_be[i])
                    mem[l_word[AW-1:0]][8*i +: 8] <= l_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.err_o   = err;
    assign bus.busy_o  = busy;
    assign bus.rdata_o = rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 0 wait states) checked
// every cycle against a transaction-level model plus literal spot values.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    dmem_responder_if b0();
    dmem_responder_if b1();

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst0), .bus(b0.slave)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst(rst1), .bus(b1.slave)
    );

    int total = 0;
    int bad = 0;

    // Transaction model: per instance, an accepted request answers
    // W edges later and commits its write on the edge after that.
    int          ws [2] = '{0, 1};
    int          dw [2] = '{16, 1024};
    bit          pend [2];
    int          acc [2];
    int          edge_n [2];
    bit          p_we [2];
    logic [3:0]  p_be [2];
    logic [31:0] p_wd [2];
    bit          p_bad [2];
    int          p_idx [2];
    logic        e_ready [2];
    logic        e_err [2];
    logic        e_busy [2];
    logic [31:0] e_rdata [2];
    bit          started [2];
    logic [31:0] mm [2][1024];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic r, input logic rq,
                              input logic we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] wd);
        bit idle;
        logic [31:0] mask;
        started[k] = 1'b1;
        if (r) begin
            pend[k] = 0;
            e_ready[k] = 0;
            e_err[k] = 0;
            e_busy[k] = 0;
            e_rdata[k] = '0;
            return;
        end
        edge_n[k]++;
        idle = !pend[k];
        if (pend[k] && edge_n[k] == acc[k] + ws[k] + 1) begin
            if (p_we[k] && !p_bad[k]) begin
                mask = {{8{p_be[k][3]}}, {8{p_be[k][2]}},
                        {8{p_be[k][1]}}, {8{p_be[k][0]}}};
                mm[k][p_idx[k]] = (mm[k][p_idx[k]] & ~mask) | (p_wd[k] & mask);
            end
            pend[k] = 0;
        end
        if (idle && rq) begin
            pend[k] = 1;
            acc[k] = edge_n[k];
            p_we[k] = we;
            p_be[k] = be;
            p_wd[k] = wd;
            p_bad[k] = !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0011, 4'b1100, 4'b1111})
                       || ((a >> 2) >= 32'(dw[k]));
            p_idx[k] = int'(a >> 2);
        end
        e_busy[k] = pend[k];
        e_ready[k] = pend[k] && edge_n[k] == acc[k] + ws[k];
        e_err[k] = e_ready[k] && p_bad[k];
        if (e_ready[k] && !p_we[k])
            e_rdata[k] = p_bad[k] ? 32'h0 : mm[k][p_idx[k]];
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, b0.req_i, b0.we_i, b0.be_i, b0.addr_i, b0.wdata_i);
        model_step(1, rst1, b1.req_i, b1.we_i, b1.be_i, b1.addr_i, b1.wdata_i);
    end

    always @(negedge clk) begin
        if (started[0]) begin
            chk("ws0_ready", 32'(b0.ready_o), 32'(e_ready[0]));
            chk("ws0_busy", 32'(b0.busy_o), 32'(e_busy[0]));
            chk("ws0_rdata", b0.rdata_o, e_rdata[0]);
            if (e_ready[0]) chk("ws0_err", 32'(b0.err_o), 32'(e_err[0]));
        end
        if (started[1]) begin
            chk("ws1_ready", 32'(b1.ready_o), 32'(e_ready[1]));
            chk("ws1_busy", 32'(b1.busy_o), 32'(e_busy[1]));
            chk("ws1_rdata", b1.rdata_o, e_rdata[1]);
            if (e_ready[1]) chk("ws1_err", 32'(b1.err_o), 32'(e_err[1]));
        end
    end

    task automatic drv(input int k, input logic rq, input logic we,
                       input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd);
        if (k == 0) begin
            b0.req_i = rq; b0.we_i = we; b0.be_i = be;
            b0.addr_i = a; b0.wdata_i = wd;
        end else begin
            b1.req_i = rq; b1.we_i = we; b1.be_i = be;
            b1.addr_i = a; b1.wdata_i = wd;
        end
    endtask

    task automatic txn(input int k, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat);
        bit got = 0;
        drv(k, 1'b1, we, be, a, wd);
        @(posedge clk);
        #2;
        drv(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = 0;
        rd = '0;
        er = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((k == 0 ? b0.ready_o : b1.ready_o) === 1'b1) begin
                got = 1;
                rd = (k == 0) ? b0.rdata_o : b1.rdata_o;
                er = (k == 0) ? b0.err_o : b1.err_o;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: inst %0d addr %h got no ready expected one", k, a);
        end
        @(posedge clk);
        #2;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n0, n1;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(b1.ready_o), 32'h0);
        chk("rst_busy", 32'(b1.busy_o), 32'h0);
        chk("rst_rdata", b1.rdata_o, 32'h0);
        @(posedge clk);
        #2;
        rst0 = 1'b0;
        rst1 = 1'b0;

        txn(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_err", 32'(er), 32'h0);
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", 32'(er), 32'h0);

        txn(1, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, er, lat);
        txn(1, 1'b1, 4'b0001, 32'h20, 32'h000000AA, rd, er, lat);
        txn(1, 1'b0, 4'b0001, 32'h20, 32'h0, rd, er, lat);
        chk("lane0_data", rd, 32'h112233AA);
        txn(1, 1'b1, 4'b1100, 32'h22, 32'hBBBB0000, rd, er, lat);
        txn(1, 1'b0, 4'hF, 32'h23, 32'h0, rd, er, lat);
        chk("lane32_data", rd, 32'hBBBB33AA);

        txn(1, 1'b1, 4'hF, 32'h0, 32'h01234567, rd, er, lat);
        txn(1, 1'b1, 4'hF, 32'h4, 32'h89ABCDEF, rd, er, lat);
        txn(1, 1'b0, 4'b0101, 32'h0, 32'h0, rd, er, lat);
        chk("badbe_err", 32'(er), 32'h1);
        chk("badbe_data", rd, 32'h0);
        txn(1, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
        chk("oor_err", 32'(er), 32'h1);
        chk("wr_keeps_rdata", rd, 32'h0);
        txn(1, 1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
        chk("word0_kept", rd, 32'h01234567);
        chk("word0_err", 32'(er), 32'h0);

        txn(0, 1'b1, 4'hF, 32'h0, 32'hA0A0A0A0, rd, er, lat);
        chk("ws0_wr_lat", 32'(lat), 32'd1);
        txn(0, 1'b1, 4'hF, 32'h4, 32'hB1B1B1B1, rd, er, lat);
        txn(0, 1'b0, 4'hF, 32'h4, 32'h0, rd, er, lat);
        chk("ws0_rd_data", rd, 32'hB1B1B1B1);
        txn(0, 1'b0, 4'hF, 32'h40, 32'h0, rd, er, lat);
        chk("ws0_oor_err", 32'(er), 32'h1);

        n0 = 0;
        n1 = 0;
        drv(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        drv(1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b0.ready_o === 1'b1) n0++;
            if (b1.ready_o === 1'b1) n1++;
            drv(0, 1'b1, 1'b0, 4'hF, (i % 2 == 0) ? 32'h4 : 32'h0, 32'h0);
            drv(1, 1'b1, 1'b0, 4'hF, (i % 2 == 0) ? 32'h4 : 32'h0, 32'h0);
        end
        drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        chk("pulses_ws1", 32'(n1), 32'd4);
        chk("pulses_ws0", 32'(n0), 32'd6);

        txn(1, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D, rd, er, lat);
        drv(1, 1'b1, 1'b1, 4'b0001, 32'h8, 32'h55);
        @(posedge clk);
        #2;
        drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst1 = 1'b1;
        @(posedge clk);
        #2;
        rst1 = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(b1.ready_o), 32'h0);
        chk("abort_busy", 32'(b1.busy_o), 32'h0);
        chk("abort_err", 32'(b1.err_o), 32'h0);
        chk("abort_rdata", b1.rdata_o, 32'h0);
        @(posedge clk);
        #2;
        txn(1, 1'b0, 4'hF, 32'h8, 32'h0, rd, er, lat);
        chk("abort_kept", rd, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of extra cycles inserted between request acceptance and response (0 to 15).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_i, input, 1, core requests an access this cycle.
REQ-006 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port be_i, input, 4, byte enables; bit n selects byte lane n (bits 8n+7:8n).
REQ-008 SHALL have port addr_i, input, 32, byte address from the core EX/MEM stage.
REQ-009 SHALL have port wdata_i, input, 32, write data, lane-aligned.
REQ-010 SHALL have port rdata_o, output, 32, full read word at the addressed index.
REQ-011 SHALL have port ready_o, output, 1, one-cycle response strobe.
REQ-012 SHALL have port err_o, output, 1, access rejected; valid only while ready_o=1.
REQ-013 SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 In IDLE with req_i=1, SHALL latch we_i, be_i, addr_i and wdata_i. SHALL then move to WAIT with wait counter = WAIT_STATES-1, or directly to RESP when WAIT_STATES=0.
REQ-016 In WAIT, SHALL decrement the counter each cycle and move to RESP in the cycle after the counter reads 0.
REQ-017 In RESP, SHALL drive ready_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: a request accepted at edge T SHALL produce ready_o=1 in cycle T+1+WAIT_STATES; throughput is one access per WAIT_STATES+2 cycles.
REQ-019 req_i SHALL be ignored in WAIT and RESP; the latched request SHALL NOT change while busy_o=1.
REQ-020 Word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2].
REQ-021 Legal be values: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
REQ-022 A request SHALL be in range when addr[31:2] < DEPTH_WORDS.
REQ-023 A write SHALL update only the enabled byte lanes, at the edge that ends the RESP cycle, and only when be is legal and the address is in range.
REQ-024 A read SHALL load rdata_o with the full stored word, all lanes regardless of be, at the edge entering RESP.
REQ-025 rdata_o SHALL hold its value until the next read response; writes SHALL NOT change rdata_o.
REQ-026 err_o SHALL be 1 in RESP if be is illegal or the address is out of range. No storage update SHALL occur, and a read SHALL return rdata_o=0.
REQ-027 addr[1:0] SHALL be ignored for indexing; lane selection is solely by be.
REQ-028 The storage array SHALL be single-ported; no read and write SHALL occur in the same cycle.

Reset
REQ-029 On rst=1, SHALL enter IDLE and force ready_o=0, err_o=0, busy_o=0, rdata_o=0x00000000, with the wait counter cleared.
REQ-030 rst asserted in WAIT or RESP SHALL abort the access: no write and no ready_o pulse.
REQ-031 rst SHALL NOT clear the storage array contents.
REQ-032 rst SHALL take priority over req_i in the same cycle.

Verification
REQ-033 Full-word write and read (WAIT_STATES=1): write addr 0x10, be 1111, wdata 0xDEADBEEF. Then read addr 0x10 -> ready_o two cycles after each accept, rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Byte-lane write: write 0x11223344 to 0x20 (be 1111), then write 0x000000AA with be 0001. Read 0x20 -> rdata_o=0x112233AA. Then write 0xBBBB0000 with be 1100 and read -> 0xBBBB33AA.
REQ-035 Error response: read with be 0101 -> ready_o=1, err_o=1, rdata_o=0. Write to addr 4*DEPTH_WORDS with be 1111 -> err_o=1; word 0 unchanged on readback.
REQ-036 Busy behaviour: req_i held high continuously with reads of 0x0, 0x4 alternating each cycle -> accepts only in IDLE, one ready_o per 3 cycles (WAIT_STATES=1). With WAIT_STATES=0, one ready_o per 2 cycles.
REQ-037 Reset mid-write: accept write 0x55 to 0x8 (be 0001), assert rst in the WAIT cycle -> no ready_o, all outputs 0. Then read 0x8 -> previous contents returned.
